// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin hold arbiter.
// Contents:
//   ST_IDLE / ST_GRANT : FSM state encoding
//   id_width()         : width of a requester index, never below 1 bit
//   cnt_width()        : width of a counter that must reach max_hold without wrapping
package arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int unsigned DEF_N        = 3;
  localparam int unsigned DEF_MAX_HOLD = 8;

  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set-bit finder used by the round-robin arbiter.
// Ports:
//   req   [N-1:0]  request vector
//   ptr   [IW-1:0] search start index (0..N-1)
//   valid          any request set
//   idx   [IW-1:0] first set index at or after ptr, wrapping modulo N
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned IW = id_width(DEF_N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    // Rotating the doubled vector right by ptr puts req[ptr] at bit 0, so a
    // plain lowest-bit priority encode gives the cyclic distance from ptr.
    rot   = N'({req, req} >> ptr);
    valid = |req;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) idx = IW'(sum - (IW + 1)'(N));
    else                     idx = IW'(sum);
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded grant tenure.
// A holder keeps the grant while its req stays high; after MAX_HOLD cycles it
// is pre-empted only if someone else is waiting. Every owner change passes
// through one IDLE cycle with gnt low.
// Ports:
//   clk      clock, all logic on posedge
//   reset    synchronous active-low reset
//   req      [N-1:0] request vector
//   gnt      [N-1:0] registered one-hot grant
//   gnt_id   index of current holder, 0 when idle
//   busy     any grant active
//   expired  one-cycle pulse on the edge a holder is pre-empted
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 expired
);

  localparam int unsigned IW = id_width(N);
  localparam int unsigned HW = cnt_width(MAX_HOLD);

  logic          state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic          expired_q, expired_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          holder_req;
  logic          others_req;
  logic [IW-1:0] ptr_after;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // gnt_q is one-hot for the holder, so it doubles as the holder mask.
  assign holder_req = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign ptr_after  = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    expired_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_GRANT;
          gnt_d    = N'(1) << pick_idx;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
          hold_d   = HW'(1);
        end
      end
      default: begin
        if (!holder_req || (hold_q == HW'(MAX_HOLD) && others_req)) begin
          // Release or pre-empt: both hand over via an IDLE slot.
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          busy_d    = 1'b0;
          ptr_d     = ptr_after;
          expired_d = holder_req;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule
